mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter port_cnt, default 5 (peval_width**2 instruction ports + 1 data port), meaning the number of requester ports; legal range 2..8.
REQ-002 SHALL have parameter max_outstanding, default 4, meaning the tag FIFO depth; legal range 1..8.
REQ-003 SHALL have port clk  input  1  core clock.
REQ-004 SHALL have port rst  input  1 (bool)  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1 (bool)  global enable; when low, no new grants are issued.
REQ-006 SHALL have port req_valid  input  [port_cnt]  requester read request pending.
REQ-007 SHALL have port req_addr  input  [port_cnt][32]  requester byte address.
REQ-008 SHALL have port req_rdy  output  [port_cnt]  one-hot grant; the request is accepted this cycle.
REQ-009 SHALL have port rsp_valid  output  [port_cnt]  one-hot; read data is returned to that requester.
REQ-010 SHALL have port rsp_data  output  [32]  read data, shared by all requesters.
REQ-011 SHALL have port mem_req_valid  output  1  request to backing memory.
REQ-012 SHALL have port mem_req_addr  output  [32]  backing memory address.
REQ-013 SHALL have port mem_req_rdy  input  1  backing memory accepts the request.
REQ-014 SHALL have port mem_rsp_valid  input  1  backing memory returns data; responses are in order.
REQ-015 SHALL have port mem_rsp_data  input  [32]  backing memory data.
REQ-016 SHALL have port err_unexp  output  1  sticky flag: a response arrived with no outstanding request.

Function
REQ-017 SHALL select one winner per cycle among ports with req_valid set, using round-robin from pointer rr_ptr.
REQ-018 SHALL grant only when en=1, mem_req_rdy=1, and the tag FIFO is not full, or is full and is popped in the same cycle.
REQ-019 SHALL, on grant, combinationally drive mem_req_valid=1, mem_req_addr=req_addr[winner] and req_rdy[winner]=1, and shall drive all other req_rdy bits to 0.
REQ-020 SHALL, on grant, push winner into the tag FIFO and set rr_ptr=(winner+1) mod port_cnt at the clock edge.
REQ-021 SHALL, on mem_rsp_valid with a non-empty FIFO, drive rsp_valid[head]=1 and rsp_data=mem_rsp_data in the same cycle, and pop the head.
REQ-022 SHALL return response data with a total latency of the memory latency plus zero added cycles; there are no internal data registers.
REQ-023 SHALL, on mem_rsp_valid with an empty FIFO, drive all rsp_valid bits to 0, set err_unexp, and leave the FIFO unchanged.
REQ-024 SHALL allow a push and a pop in the same cycle; the count is unchanged, and the FIFO pointers wrap modulo max_outstanding.
REQ-025 SHALL, when en=0, still route and pop responses; only grants are blocked.
REQ-026 SHALL drive rsp_data=0 when no response is being routed.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, clear the FIFO (count=0, pointers=0), set rr_ptr=0, and clear err_unexp.
REQ-028 SHALL, while rst=1, drive req_rdy=0, mem_req_valid=0 and rsp_valid=0 regardless of the other inputs.
REQ-029 SHALL discard responses to requests outstanding at a reset applied mid-operation; those responses are then counted as unexpected per REQ-023.

Configuration
REQ-030 SHALL, with macro MEM_REQ_ARBITER_DATA_PRIO_EN defined, give port port_cnt-1 (the data port) absolute priority over round-robin and leave rr_ptr unchanged on its grants.
REQ-031 SHALL, without MEM_REQ_ARBITER_DATA_PRIO_EN, treat every port, including the data port, with pure round-robin per REQ-017.

Verification
REQ-032 SHALL cover this case: ports 0, 2 and 4 request continuously with mem_req_rdy=1 -> grants go 0, 2, 4, 0 on successive cycles (macro off).
REQ-033 SHALL cover this case: with the macro on, ports 1 and 4 request continuously -> port 4 is granted every cycle and port 1 is never granted.
REQ-034 SHALL cover this case: max_outstanding=4, four grants, no responses -> the fifth request is stalled (req_rdy=0); one mem_rsp_valid that cycle -> the grant proceeds.
REQ-035 SHALL cover this case: grants to ports 3 then 1, then responses 0xAAAA0000 and 0x5555FFFF -> rsp_valid[3] with 0xAAAA0000, then rsp_valid[1] with 0x5555FFFF.
REQ-036 SHALL cover this case: mem_rsp_valid=1 with an empty FIFO -> err_unexp=1 on the next cycle, held until rst.
REQ-037 SHALL cover this case: rst=1 with 2 requests outstanding -> FIFO empty afterwards, and the next 2 responses set err_unexp without any rsp_valid.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// Handshake bundle between the requester ports, the arbiter and the backing memory.
// The arbiter connects through the slave modport; the environment drives the master side.
interface mem_req_arbiter_if #(
  parameter int port_cnt = 5
);
  logic [port_cnt-1:0]       req_valid;
  logic [port_cnt-1:0][31:0] req_addr;
  logic [port_cnt-1:0]       req_rdy;
  logic [port_cnt-1:0]       rsp_valid;
  logic [31:0]               rsp_data;
  logic                      mem_req_valid;
  logic [31:0]               mem_req_addr;
  logic                      mem_req_rdy;
  logic                      mem_rsp_valid;
  logic [31:0]               mem_rsp_data;

  modport slave (
    input  req_valid, req_addr, mem_req_rdy, mem_rsp_valid, mem_rsp_data,
    output req_rdy, rsp_valid, rsp_data, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, mem_req_rdy, mem_rsp_valid, mem_rsp_data,
    input  req_rdy, rsp_valid, rsp_data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin read arbiter with an in-order tag FIFO routing memory responses back to requesters.
// Optional macro MEM_REQ_ARBITER_DATA_PRIO_EN gives the last (data) port absolute priority.
module mem_req_arbiter #(
  parameter int port_cnt        = 5,
  parameter int max_outstanding = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  mem_req_arbiter_if.slave    bus,
  output logic                err_unexp
);
  localparam int PW = $clog2(port_cnt);
  localparam int TW = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;
  localparam int CW = $clog2(max_outstanding + 1);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_win;
  logic [PW-1:0] win;
  logic          rr_found;
  logic          prio_hit;
  logic          any_req;
  logic          room;
  logic          grant;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [TW-1:0] wr_ptr;
  logic [TW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] tag_mem [max_outstanding];
  logic [PW-1:0] head_tag;

  function automatic logic [TW-1:0] nxt_tag_ptr(input logic [TW-1:0] p);
    return (p == TW'(max_outstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] nxt_port(input logic [PW-1:0] p);
    return (p == PW'(port_cnt - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scan requesters starting at rr_ptr, wrapping modulo port_cnt.
  always_comb begin
    logic [PW:0] sum;
    logic [PW-1:0] idx;
    sum      = '0;
    idx      = '0;
    rr_found = 1'b0;
    rr_win   = '0;
    for (int k = 0; k < port_cnt; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      idx = (sum >= (PW+1)'(port_cnt)) ? PW'(sum - (PW+1)'(port_cnt)) : PW'(sum);
      if (!rr_found && bus.req_valid[idx]) begin
        rr_found = 1'b1;
        rr_win   = idx;
      end
    end
  end

  always_comb begin
    win      = rr_win;
    prio_hit = 1'b0;
`ifdef MEM_REQ_ARBITER_DATA_PRIO_EN
    if (bus.req_valid[port_cnt-1]) begin
      win      = PW'(port_cnt - 1);
      prio_hit = 1'b1;
    end
`endif
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(max_outstanding));
  assign head_tag   = tag_mem[rd_ptr];
  assign any_req    = |bus.req_valid;
  assign pop        = !rst && bus.mem_rsp_valid && !fifo_empty;
  assign room       = !fifo_full || pop;
  assign grant      = !rst && en && bus.mem_req_rdy && any_req && room;

  // Grant and response routing are purely combinational: zero added latency.
  always_comb begin
    bus.req_rdy   = '0;
    bus.rsp_valid = '0;
    for (int i = 0; i < port_cnt; i++) begin
      bus.req_rdy[i]   = grant && (win == PW'(i));
      bus.rsp_valid[i] = pop && (head_tag == PW'(i));
    end
    bus.mem_req_valid = grant;
    bus.mem_req_addr  = grant ? bus.req_addr[win] : '0;
    bus.rsp_data      = pop ? bus.mem_rsp_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (grant) begin
        wr_ptr <= nxt_tag_ptr(wr_ptr);
        if (!prio_hit) rr_ptr <= nxt_port(win);
      end
      if (pop) rd_ptr <= nxt_tag_ptr(rd_ptr);
      if (grant && !pop) count <= count + 1'b1;
      else if (pop && !grant) count <= count - 1'b1;
      if (bus.mem_rsp_valid && fifo_empty) err_unexp <= 1'b1;
    end
  end

  // Tag storage carries data only and is not reset.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= win;
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: a queue-based reference model predicts grants and routed
// responses; a negedge monitor pops and compares whenever the arbiter presents an output.
module tb_mem_req_arbiter;
  localparam int N = 5;
  localparam int M = 4;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic err_unexp;

  mem_req_arbiter_if #(.port_cnt(N)) bus ();

  mem_req_arbiter #(.port_cnt(N), .max_outstanding(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bus       (bus.slave),
    .err_unexp (err_unexp)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  ev_t  gnt_q[$];
  ev_t  rsp_q[$];
  int   outq[$];
  int   rr = 0;
  logic exp_err_cur = 1'b0;
  logic exp_err_nxt = 1'b0;

  logic        s_rst, s_en, s_mrdy, s_mrv;
  logic [N-1:0] s_rv;
  logic [31:0] s_mdata;
  logic [31:0] s_addr [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one call covers one clock cycle.
  task automatic step();
    int  win;
    bit  prio;
    bit  pop;
    bit  room;
    exp_err_cur = exp_err_nxt;
    cyc++;
    rst               = s_rst;
    en                = s_en;
    bus.req_valid     = s_rv;
    for (int i = 0; i < N; i++) bus.req_addr[i] = s_addr[i];
    bus.mem_req_rdy   = s_mrdy;
    bus.mem_rsp_valid = s_mrv;
    bus.mem_rsp_data  = s_mdata;
    if (s_rst) begin
      outq.delete();
      rr = 0;
      exp_err_nxt = 1'b0;
    end else begin
      pop  = s_mrv && (outq.size() > 0);
      room = (outq.size() < M) || pop;
      if (pop) begin
        rsp_q.push_back('{cyc, outq[0], s_mdata});
        void'(outq.pop_front());
      end else if (s_mrv) begin
        exp_err_nxt = 1'b1;
      end
      win  = -1;
      prio = 1'b0;
`ifdef MEM_REQ_ARBITER_DATA_PRIO_EN
      if (s_rv[N-1]) begin
        win  = N - 1;
        prio = 1'b1;
      end
`endif
      if (win < 0) begin
        for (int k = 0; k < N; k++) begin
          if (s_rv[(rr + k) % N]) begin
            win = (rr + k) % N;
            break;
          end
        end
      end
      if (win >= 0 && s_en && s_mrdy && room) begin
        gnt_q.push_back('{cyc, win, s_addr[win]});
        outq.push_back(win);
        if (!prio) rr = (win + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [N-1:0] rv, input logic mrdy,
                       input logic mrv, input logic [31:0] md);
    s_rst = r; s_en = e; s_rv = rv; s_mrdy = mrdy; s_mrv = mrv; s_mdata = md;
    for (int i = 0; i < N; i++) s_addr[i] = $urandom;
    step();
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (bus.req_rdy != '0) begin
        if (gnt_q.size() == 0) begin
          chk("gnt_unexpected", 64'(bus.req_rdy), 64'd0);
        end else begin
          e = gnt_q.pop_front();
          chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
          chk("gnt_port", 64'(bus.req_rdy), 64'd1 << e.port);
          chk("mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
          chk("mem_req_addr", 64'(bus.mem_req_addr), 64'(e.data));
        end
      end else begin
        chk("mem_req_valid_idle", 64'(bus.mem_req_valid), 64'd0);
      end
      if (bus.rsp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
          chk("rsp_port", 64'(bus.rsp_valid), 64'd1 << e.port);
          chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
        end
      end else begin
        chk("rsp_data_idle", 64'(bus.rsp_data), 64'd0);
      end
      chk("err_unexp", 64'(err_unexp), 64'(exp_err_cur));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0;
    bus.req_valid = '0; bus.req_addr = '0; bus.mem_req_rdy = 1'b0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset held with live inputs: nothing may be granted or routed.
    repeat (2) drive(1, 1, 5'b11111, 1, 1, 32'h1234_5678);

    // Ports 0, 2, 4 requesting; fifth request stalls on a full FIFO until a pop.
    repeat (4) drive(0, 1, 5'b10101, 1, 0, 32'h0);
    drive(0, 1, 5'b10101, 1, 0, 32'h0);
    drive(0, 1, 5'b10101, 1, 1, 32'h1111_0001);
    repeat (4) drive(0, 1, 5'b00000, 1, 1, $urandom);

    // Grants to 3 then 1, responses routed in order.
    drive(1, 0, 5'b00000, 0, 0, 32'h0);
    drive(0, 1, 5'b01000, 1, 0, 32'h0);
    drive(0, 1, 5'b00010, 1, 0, 32'h0);
    drive(0, 1, 5'b00000, 1, 1, 32'hAAAA_0000);
    drive(0, 1, 5'b00000, 1, 1, 32'h5555_FFFF);

    // Response with empty FIFO: sticky error until reset.
    drive(0, 1, 5'b00000, 1, 1, 32'hDEAD_BEEF);
    repeat (3) drive(0, 1, 5'b00000, 1, 0, 32'h0);

    // Reset with two outstanding requests: their responses become unexpected.
    drive(1, 0, 5'b00000, 0, 0, 32'h0);
    drive(0, 1, 5'b00100, 1, 0, 32'h0);
    drive(0, 1, 5'b01000, 1, 0, 32'h0);
    drive(1, 0, 5'b00000, 0, 0, 32'h0);
    drive(0, 1, 5'b00000, 1, 1, 32'h0BAD_0001);
    drive(0, 1, 5'b00000, 1, 1, 32'h0BAD_0002);
    drive(0, 1, 5'b00000, 1, 0, 32'h0);

    // Ports 1 and 4 continuously with a steady response stream.
    drive(1, 0, 5'b00000, 0, 0, 32'h0);
    repeat (8) drive(0, 1, 5'b10010, 1, 1, $urandom);

    // Enable low: responses still drain, no grants.
    repeat (3) drive(0, 0, 5'b11111, 1, 1, $urandom);

    // Randomized traffic with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), N'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 4), $urandom);
    end

    // Drain and settle.
    drive(1, 0, 5'b00000, 0, 0, 32'h0);
    drive(0, 0, 5'b00000, 0, 0, 32'h0);
    mon_en = 1'b0;
    chk("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
